// File: rtl/rv_fifo.sv
// rv_fifo: ready/valid mailbox FIFO that sits behind the AXI-lite-to-ready/valid
// bridge. Bridge writes push words and bridge reads pop them. The FIFO reports
// its occupancy and keeps saturating counters of dropped writes and empty reads.
module rv_fifo #(
    parameter int DW       = 32,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH),
    parameter bit NONBLOCK = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    // write side (bridge write channel)
    input  logic          wv_i,
    output logic          wr_o,
    input  logic [DW-1:0] wd_i,
    output logic          we_o,
    // read side (bridge read channel)
    input  logic          rr_i,
    output logic          rv_o,
    output logic [DW-1:0] rd_o,
    output logic          re_o,
    // status
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [7:0]    ovf_cnt_o,
    output logic [7:0]    udf_cnt_o
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic [7:0]    ovf_cnt_q, ovf_cnt_d;
    logic [7:0]    udf_cnt_q, udf_cnt_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic ovf_hit;
    logic udf_hit;

    // Handshake outputs and transfer qualifiers, derived only from registered state
    // so ready never depends on valid and vice versa.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that leaves a
        // signal unassigned would infer a latch.
        full    = (level_q == FULL_LEVEL);
        empty   = (level_q == '0);
        wr_o    = 1'b1;
        rv_o    = 1'b1;
        we_o    = 1'b0;
        re_o    = 1'b0;
        ovf_hit = 1'b0;
        udf_hit = 1'b0;
        if (NONBLOCK) begin
            // Bus never stalls: full/empty are reported as error responses instead.
            we_o    = full;
            re_o    = empty;
            ovf_hit = wv_i & full;
            udf_hit = rr_i & empty;
        end else begin
            wr_o = ~full;
            rv_o = ~empty;
        end
        // Full/empty are evaluated on pre-update state, so a full FIFO refuses the
        // write while popping, and an empty FIFO refuses the read while pushing.
        push = wv_i & wr_o & ~full;
        pop  = rv_o & rr_i & ~empty;
    end

    // Next-state for pointers, occupancy and saturating error counters.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        level_d   = level_q;
        ovf_cnt_d = ovf_cnt_q;
        udf_cnt_d = udf_cnt_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
        if (ovf_hit && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
        if (udf_hit && (udf_cnt_q != 8'hFF)) begin
            udf_cnt_d = udf_cnt_q + 8'd1;
        end
    end

    // Control state register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            ovf_cnt_q <= ovf_cnt_d;
            udf_cnt_q <= udf_cnt_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; occupancy gates every read, so stale
        // contents are never observed and the array can map onto plain RAM.
        if (push) begin
            mem[wptr_q] <= wd_i;
        end
    end

    // First-word-fall-through read data and status outputs; no bypass from wd_i.
    always_comb begin
        rd_o      = empty ? '0 : mem[rptr_q];
        level_o   = level_q;
        full_o    = full;
        empty_o   = empty;
        ovf_cnt_o = ovf_cnt_q;
        udf_cnt_o = udf_cnt_q;
    end

endmodule

// File: tb/tb_rv_fifo.sv
// tb_rv_fifo: directed bench for rv_fifo with DEPTH=4. A table of per-cycle
// vectors drives the non-blocking instance; hand-written sequences cover the
// blocking instance, counter saturation and asynchronous reset.
module tb_rv_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // non-blocking instance
    logic          wv1, rr1;
    logic [DW-1:0] wd1;
    logic          wr1, we1, rv1, re1, full1, empty1;
    logic [DW-1:0] rd1;
    logic [AW:0]   lvl1;
    logic [7:0]    ovf1, udf1;

    // blocking instance
    logic          wv0, rr0;
    logic [DW-1:0] wd0;
    logic          wr0, we0, rv0, re0, full0, empty0;
    logic [DW-1:0] rd0;
    logic [AW:0]   lvl0;
    logic [7:0]    ovf0, udf0;

    rv_fifo #(.DW(DW), .DEPTH(DEPTH), .NONBLOCK(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .wv_i(wv1), .wr_o(wr1), .wd_i(wd1), .we_o(we1),
        .rr_i(rr1), .rv_o(rv1), .rd_o(rd1), .re_o(re1),
        .level_o(lvl1), .full_o(full1), .empty_o(empty1),
        .ovf_cnt_o(ovf1), .udf_cnt_o(udf1)
    );

    rv_fifo #(.DW(DW), .DEPTH(DEPTH), .NONBLOCK(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .wv_i(wv0), .wr_o(wr0), .wd_i(wd0), .we_o(we0),
        .rr_i(rr0), .rv_o(rv0), .rd_o(rd0), .re_o(re0),
        .level_o(lvl0), .full_o(full0), .empty_o(empty0),
        .ovf_cnt_o(ovf0), .udf_cnt_o(udf0)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One vector = inputs for a cycle plus the outputs expected before that edge.
    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic        rr;
        logic [31:0] rd;
        logic        re;
        logic        we;
        logic [2:0]  lvl;
        logic [7:0]  ovf;
        logic [7:0]  udf;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic wv, input logic [31:0] wd, input logic rr,
                       input logic [31:0] rd, input logic re, input logic we,
                       input logic [2:0] lvl, input logic [7:0] ovf, input logic [7:0] udf);
        vec_t v;
        v = '{wv, wd, rr, rd, re, we, lvl, ovf, udf};
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //   wv  wd        rr  rd        re  we  lvl ovf udf
        // in-order push/pop of three words
        add(1, 32'h11, 0, 32'h0,  1, 0, 0, 0, 0);
        add(1, 32'h22, 0, 32'h11, 0, 0, 1, 0, 0);
        add(1, 32'h33, 0, 32'h11, 0, 0, 2, 0, 0);
        add(0, 32'h0,  1, 32'h11, 0, 0, 3, 0, 0);
        add(0, 32'h0,  1, 32'h22, 0, 0, 2, 0, 0);
        add(0, 32'h0,  1, 32'h33, 0, 0, 1, 0, 0);
        add(0, 32'h0,  0, 32'h0,  1, 0, 0, 0, 0);
        // overfill: fifth write dropped with we_o=1
        add(1, 32'hA0, 0, 32'h0,  1, 0, 0, 0, 0);
        add(1, 32'hA1, 0, 32'hA0, 0, 0, 1, 0, 0);
        add(1, 32'hA2, 0, 32'hA0, 0, 0, 2, 0, 0);
        add(1, 32'hA3, 0, 32'hA0, 0, 0, 3, 0, 0);
        add(1, 32'hA4, 0, 32'hA0, 0, 1, 4, 0, 0);
        // full + simultaneous write/read: pop wins, write dropped
        add(1, 32'hB0, 1, 32'hA0, 0, 1, 4, 1, 0);
        add(0, 32'h0,  0, 32'hA1, 0, 0, 3, 2, 0);
        add(0, 32'h0,  1, 32'hA1, 0, 0, 3, 2, 0);
        // level 2: simultaneous push/pop across the pointer wrap
        add(1, 32'hC0, 1, 32'hA2, 0, 0, 2, 2, 0);
        add(1, 32'hC1, 1, 32'hA3, 0, 0, 2, 2, 0);
        add(1, 32'hC2, 1, 32'hC0, 0, 0, 2, 2, 0);
        add(1, 32'hC3, 1, 32'hC1, 0, 0, 2, 2, 0);
        add(1, 32'hC4, 1, 32'hC2, 0, 0, 2, 2, 0);
        add(1, 32'hC5, 1, 32'hC3, 0, 0, 2, 2, 0);
        add(1, 32'hC6, 1, 32'hC4, 0, 0, 2, 2, 0);
        add(1, 32'hC7, 1, 32'hC5, 0, 0, 2, 2, 0);
        add(0, 32'h0,  1, 32'hC6, 0, 0, 2, 2, 0);
        add(0, 32'h0,  1, 32'hC7, 0, 0, 1, 2, 0);
        add(0, 32'h0,  0, 32'h0,  1, 0, 0, 2, 0);
        // reads while empty
        add(0, 32'h0,  1, 32'h0,  1, 0, 0, 2, 0);
        add(0, 32'h0,  1, 32'h0,  1, 0, 0, 2, 1);
        add(0, 32'h0,  0, 32'h0,  1, 0, 0, 2, 2);

        rst = 1'b1;
        wv1 = 1'b0; rr1 = 1'b0; wd1 = '0;
        wv0 = 1'b0; rr0 = 1'b0; wd0 = '0;
        @(negedge clk);
        @(negedge clk);

        // reset values
        check("rst wr1",    32'(wr1),    32'd1);
        check("rst rv1",    32'(rv1),    32'd1);
        check("rst re1",    32'(re1),    32'd1);
        check("rst we1",    32'(we1),    32'd0);
        check("rst rd1",    rd1,         32'd0);
        check("rst empty1", 32'(empty1), 32'd1);
        check("rst full1",  32'(full1),  32'd0);
        check("rst lvl1",   32'(lvl1),   32'd0);
        check("rst rv0",    32'(rv0),    32'd0);
        check("rst re0",    32'(re0),    32'd0);
        check("rst wr0",    32'(wr0),    32'd1);
        rst = 1'b0;
        tick();

        // table-driven vectors on the non-blocking instance
        for (int i = 0; i < vq.size(); i++) begin
            wv1 = vq[i].wv;
            wd1 = vq[i].wd;
            rr1 = vq[i].rr;
            #1;
            check($sformatf("v%0d rd", i),    rd1,           vq[i].rd);
            check($sformatf("v%0d re", i),    32'(re1),      32'(vq[i].re));
            check($sformatf("v%0d we", i),    32'(we1),      32'(vq[i].we));
            check($sformatf("v%0d lvl", i),   32'(lvl1),     32'(vq[i].lvl));
            check($sformatf("v%0d full", i),  32'(full1),    32'(vq[i].lvl == 3'd4));
            check($sformatf("v%0d empty", i), 32'(empty1),   32'(vq[i].lvl == 3'd0));
            check($sformatf("v%0d ovf", i),   32'(ovf1),     32'(vq[i].ovf));
            check($sformatf("v%0d udf", i),   32'(udf1),     32'(vq[i].udf));
            check($sformatf("v%0d hs", i),    32'({wr1, rv1}), 32'd3);
            tick();
        end

        // underflow counter saturation: 2 so far, 300 more reads
        for (int i = 0; i < 300; i++) begin
            rr1 = 1'b1;
            tick();
        end
        rr1 = 1'b0;
        #1;
        check("udf sat", 32'(udf1), 32'd255);
        check("udf sat re", 32'(re1), 32'd1);
        check("udf sat rd", rd1, 32'd0);
        @(negedge clk);

        // asynchronous reset with level 3 and a write pending
        for (int i = 0; i < 3; i++) begin
            wv1 = 1'b1;
            wd1 = 32'hE0 + 32'(i);
            tick();
        end
        wv1 = 1'b1;
        wd1 = 32'hE3;
        #1;
        check("pre-rst lvl", 32'(lvl1), 32'd3);
        check("pre-rst rd",  rd1,       32'hE0);
        #1;
        rst = 1'b1;
        #1;
        check("arst lvl",   32'(lvl1),   32'd0);
        check("arst empty", 32'(empty1), 32'd1);
        check("arst full",  32'(full1),  32'd0);
        check("arst we",    32'(we1),    32'd0);
        check("arst re",    32'(re1),    32'd1);
        check("arst rd",    rd1,         32'd0);
        check("arst ovf",   32'(ovf1),   32'd0);
        check("arst udf",   32'(udf1),   32'd0);
        wv1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rr1 = 1'b1;
        #1;
        check("post-rst rv", 32'(rv1), 32'd1);
        check("post-rst re", 32'(re1), 32'd1);
        check("post-rst rd", rd1,      32'd0);
        tick();
        rr1 = 1'b0;
        #1;
        check("post-rst udf", 32'(udf1), 32'd1);
        @(negedge clk);

        // blocking instance: read while empty stalls until a push
        rr0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("nb0 stall rv %0d", i), 32'(rv0), 32'd0);
            tick();
        end
        wv0 = 1'b1;
        wd0 = 32'hCAFE;
        #1;
        check("nb0 no bypass rv", 32'(rv0), 32'd0);
        check("nb0 no bypass rd", rd0,      32'd0);
        tick();
        wv0 = 1'b0;
        #1;
        check("nb0 fwft rv", 32'(rv0), 32'd1);
        check("nb0 fwft rd", rd0,      32'hCAFE);
        check("nb0 fwft re", 32'(re0), 32'd0);
        tick();
        rr0 = 1'b0;
        #1;
        check("nb0 drained rv",  32'(rv0),    32'd0);
        check("nb0 drained emp", 32'(empty0), 32'd1);
        check("nb0 udf",         32'(udf0),   32'd0);
        @(negedge clk);

        // blocking instance: full withholds wr_o until a pop
        for (int i = 0; i < 4; i++) begin
            wv0 = 1'b1;
            wd0 = 32'hD0 + 32'(i);
            #1;
            check($sformatf("nb0 fill wr %0d", i), 32'(wr0), 32'd1);
            tick();
        end
        #1;
        check("nb0 full wr",   32'(wr0),   32'd0);
        check("nb0 full flag", 32'(full0), 32'd1);
        check("nb0 full lvl",  32'(lvl0),  32'd4);
        tick();
        #1;
        check("nb0 hold lvl", 32'(lvl0), 32'd4);
        check("nb0 hold we",  32'(we0),  32'd0);
        check("nb0 hold ovf", 32'(ovf0), 32'd0);
        check("nb0 hold wr",  32'(wr0),  32'd0);
        rr0 = 1'b1;
        #1;
        check("nb0 pop rd", rd0, 32'hD0);
        tick();
        rr0 = 1'b0;
        #1;
        check("nb0 after pop wr",  32'(wr0),  32'd1);
        check("nb0 after pop lvl", 32'(lvl0), 32'd3);
        check("nb0 after pop rd",  rd0,       32'hD1);
        tick();
        wv0 = 1'b0;
        #1;
        check("nb0 refill lvl", 32'(lvl0), 32'd4);
        check("nb0 refill wr",  32'(wr0),  32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rv_fifo.md
Name: rv_fifo

Overview:
- Ready/valid FIFO endpoint that sits directly downstream of the AXI-lite-to-ready/valid bridge on one user port (A or B).
- Bridge write transfers (wvalid/wready/wdata/werror) push words into the FIFO.
- Bridge read transfers (rready/rvalid/rdata/rerror) pop words from the FIFO.
- Gives software a CPU-accessible mailbox queue behind a single AXI address, with occupancy status and error counters.

Parameters:
- DW, 32, data width; matches bridge wdata/rdata width.
- DEPTH, 16, number of entries; must be a power of two and at least 2.
- AW, $clog2(DEPTH), pointer width; derived, do not override.
- NONBLOCK, 1:
  - 1 = full/empty never stall the bus; the transfer completes with the error flag set.
  - 0 = ready/valid are withheld while full/empty.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset
- wv_i  in  1  write valid from bridge (bridge wvalid_o)
- wr_o  out  1  write ready to bridge (bridge wready_i)
- wd_i  in  DW  write data from bridge (bridge wdata_o)
- we_o  out  1  write error to bridge (bridge werror_i); meaningful only when wv_i & wr_o
- rr_i  in  1  read ready from bridge (bridge rready_o)
- rv_o  out  1  read valid to bridge (bridge rvalid_i)
- rd_o  out  DW  read data to bridge (bridge rdata_i)
- re_o  out  1  read error to bridge (bridge rerror_i); meaningful only when rv_o & rr_i
- level_o  out  AW+1  current occupancy, 0..DEPTH
- full_o  out  1  level_o == DEPTH
- empty_o  out  1  level_o == 0
- ovf_cnt_o  out  8  dropped-write count, saturating
- udf_cnt_o  out  8  empty-read count, saturating

Interface decision: one clock; reset is asynchronous and active-high. Clock port is clk; reset port is rst.

Behaviour:
- Reset (rst high, async):
  - wptr = rptr = level = 0; ovf/udf counters = 0.
  - Outputs: empty_o=1, full_o=0, level_o=0, we_o=0.
  - re_o = NONBLOCK, rd_o = 0.
  - wr_o = 1, rv_o = NONBLOCK.
  - Storage array is not reset.
- Transfer definitions: push = wv_i & wr_o & !full; pop = rv_o & rr_i & !empty.
- Ready/valid independence:
  - wr_o never depends on wv_i.
  - rv_o never depends on rr_i.
  - No combinational path from rr_i to rv_o or from wv_i to wr_o.
- NONBLOCK=1:
  - wr_o = 1 and rv_o = 1 constantly.
  - we_o = full_o. A write while full is dropped, pointers are unchanged, ovf_cnt increments.
  - re_o = empty_o. A read while empty returns rd_o = 0, pointers are unchanged, udf_cnt increments.
- NONBLOCK=0:
  - wr_o = !full_o; rv_o = !empty_o; we_o = re_o = 0.
  - Counters stay 0.
- Read data:
  - rd_o = mem[rptr] when !empty, else 0.
  - First-word-fall-through: a word pushed in cycle N is visible on rd_o/rv_o from cycle N+1.
  - No same-cycle bypass from wd_i to rd_o.
- Push: mem[wptr] <= wd_i; wptr <= wptr+1, wrapping modulo DEPTH.
- Pop: rptr <= rptr+1, wrapping modulo DEPTH.
- Level update:
  - level += push - pop.
  - Simultaneous push and pop when 0 < level < DEPTH: level is unchanged, both pointers advance.
  - When full, simultaneous write and read: the pop succeeds and the write is refused (NONBLOCK=1: dropped with we_o=1). The full flag is evaluated before the update.
  - When empty, simultaneous write and read: the push succeeds and the read is refused (NONBLOCK=1: re_o=1, rd_o=0).
- Counters:
  - 8-bit, saturate at 255 with no wrap.
  - Cleared only by rst.
- full_o, empty_o and level_o are registered-state-derived and glitch-free relative to clk.
- Reset mid-operation: any partially held handshake is abandoned. After reset the FIFO is empty; the bridge sees rv_o=NONBLOCK on the next cycle.

Test Plan (DEPTH=4, DW=32, NONBLOCK=1 unless stated):
- Push 32'h11, 32'h22, 32'h33 via the bridge, then three reads -> rd_o returns 11, 22, 33 in order with re_o=0; level_o goes 3 -> 0; empty_o=1 at the end.
- Push 5 words A0..A4 -> first 4 accepted with we_o=0; fifth completes with we_o=1 (AXI bresp SLVERR); ovf_cnt_o=1; subsequent reads return A0..A3.
- Read while empty -> rv_o=1, re_o=1, rd_o=0 (AXI rresp SLVERR); udf_cnt_o increments each time; 300 empty reads saturate udf_cnt_o at 255.
- With level=4, assert wv_i and rr_i in the same cycle -> pop succeeds, write dropped with we_o=1, level_o=3. Repeat at level=2 -> level_o stays 2, order preserved across pointer wrap (push/pop 10 words total).
- NONBLOCK=0:
  - Read issued while empty -> rv_o stays 0 until a push of 32'hCAFE, then rv_o=1 one cycle later and rd_o=CAFE.
  - With the FIFO full, wr_o=0 until a pop.
- Assert rst asynchronously (mid-cycle) with level=3 and a write handshake pending -> all outputs take reset values immediately without waiting for a clk edge; the next read returns re_o=1, rd_o=0.
